ic_74595_sipo_rx: RTL and testbench
===================================

Name: ic_74595_sipo_rx

Overview:
- Clocked, synthesizable model of a TI 74HC595-class serial-in/parallel-out shift register with a storage register.
- Adds a frame controller: bit counter, automatic latch after WIDTH bits, valid/acknowledge flag and sticky overrun.
- Serves as the receiving end of a serial link whose transmitter is a 74HC165-class parallel-in/serial-out part.
- Sits beside the team's discrete-logic IC library as the first sequential TI-product model.

Parameters:
- WIDTH, 8, shift/storage register width in bits (legal range 2..32).
- AUTO_LATCH, 1, 1 = storage loads automatically when the WIDTH-th bit arrives; 0 = storage loads only on RCLK.

Ports:
- CLK  input  1  single system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- SER  input  1  serial data in; sampled when SRCLK_EN=1.
- SRCLK_EN  input  1  shift strobe; one bit is shifted per cycle while high.
- SRCLR_N  input  1  synchronous active-low clear of the shift register and bit counter.
- RCLK  input  1  synchronous manual latch request: shift register is copied to storage.
- RD_ACK  input  1  consumer acknowledge; clears STORE_VALID.
- OE_N  input  1  active-low output enable for Q.
- Q  output  WIDTH  storage register contents; all zeros when OE_N=1.
- Q_OE  output  1  equals ~OE_N; marks Q as driven.
- QH_S  output  1  cascade out; equals shift register MSB (sr[WIDTH-1]).
- BIT_CNT  output  clog2(WIDTH+1)  bits received in the current frame.
- FRAME_DONE  output  1  one-cycle pulse after an auto-latch.
- STORE_VALID  output  1  storage holds unread data.
- OVERRUN  output  1  sticky flag: storage was overwritten while STORE_VALID=1.

Behaviour:
- Reset (RST_N=0, asynchronous): sr, storage, BIT_CNT, FRAME_DONE, STORE_VALID and OVERRUN go to 0. As a result Q=0 and QH_S=0. Q_OE follows OE_N combinationally.
- Reset mid-frame discards the partial frame. The first bit after reset release counts as bit 1.
- Shift: when SRCLK_EN=1, sr <= {sr[WIDTH-2:0], SER}, so the first bit ends at MSB after WIDTH shifts, and BIT_CNT increments.
- State machine:
  - IDLE (BIT_CNT=0) -> SHIFT on the first strobe.
  - SHIFT -> IDLE when the WIDTH-th strobe lands; BIT_CNT wraps to 0.
  - SHIFT holds value while SRCLK_EN=0; there is no timeout.
- Auto-latch (AUTO_LATCH=1): on the edge that shifts in the WIDTH-th bit, storage loads the post-shift value {sr[WIDTH-2:0], SER}. Q shows it at the very next cycle. FRAME_DONE is high for exactly that next cycle.
- Manual latch: RCLK=1 copies the current (pre-shift) sr into storage. This matches the 595 one-stage lag when RCLK and SRCLK are tied. RCLK does not alter BIT_CNT.
- Priority on one edge:
  - SRCLR_N=0 overrides SRCLK_EN: sr and BIT_CNT become 0. Storage is untouched.
  - An auto-latch overrides RCLK.
  - RCLK with SRCLR_N=0 latches the pre-clear sr.
- STORE_VALID: set on any latch. Cleared by RD_ACK when no latch occurs on that edge. A latch plus RD_ACK on the same edge leaves it at 1.
- OVERRUN: set when a latch occurs while STORE_VALID=1 and RD_ACK=0. Cleared only by reset.
- Back-to-back frames with SRCLK_EN held high are supported with no dead cycle. One frame completes every WIDTH cycles.
- Latency: SER to QH_S is WIDTH cycles; last bit to valid Q is 1 cycle.

Test Plan:
- Reset check: assert RST_N=0 mid-frame after 3 shifts -> all outputs 0 immediately, without waiting for a clock edge. After release, shift in 8 bits of 0xA5 MSB-first -> Q=0xA5, FRAME_DONE pulses 1 cycle, STORE_VALID=1.
- Back-to-back frames: stream 0x3C then 0xC3 with SRCLK_EN held high and RD_ACK pulsed after each frame -> Q=0x3C then 0xC3; OVERRUN stays 0; BIT_CNT sequence 0..7,0..7.
- Overrun: stream two frames with no RD_ACK -> OVERRUN=1 after the second FRAME_DONE and stays 1 until reset; Q=second byte.
- Manual latch with AUTO_LATCH=0: shift 0x0F, then RCLK and SRCLK_EN high together with SER=1 -> Q=0x0F (pre-shift value); shift register becomes 0x1F.
- Clear: shift 5 bits, then SRCLR_N=0 together with SRCLK_EN=1 -> sr=0, BIT_CNT=0, Q unchanged. The next full frame of 0x81 latches 0x81.
- Output enable and cascade: with OE_N=1 after latching 0xFF -> Q=0x00 and Q_OE=0; with OE_N=0 -> Q=0xFF. QH_S equals the SER value from 8 strobes earlier.

Source files
------------

// File: rtl/ic_74595_sipo_rx.sv
// 74HC595-style serial-in/parallel-out receiver with a storage register and a frame controller.
// Adds a bit counter, automatic latch after WIDTH bits, a valid/acknowledge flag and a sticky overrun flag.
module ic_74595_sipo_rx #(
  parameter int WIDTH      = 8,
  parameter bit AUTO_LATCH = 1'b1,
  localparam int CW        = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SER,
  input  logic             SRCLK_EN,
  input  logic             SRCLR_N,
  input  logic             RCLK,
  input  logic             RD_ACK,
  input  logic             OE_N,
  output logic [WIDTH-1:0] Q,
  output logic             Q_OE,
  output logic             QH_S,
  output logic [CW-1:0]    BIT_CNT,
  output logic             FRAME_DONE,
  output logic             STORE_VALID,
  output logic             OVERRUN
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_store;
  logic [CW-1:0]    r_cnt;
  logic             r_frame_done;
  logic             r_valid;
  logic             r_overrun;

  logic             w_shift;
  logic             w_last;
  logic             w_auto;
  logic             w_latch;
  logic [WIDTH-1:0] w_sr_next;

  // A clear on the same edge suppresses the shift, so it can never complete a frame.
  assign w_shift   = SRCLK_EN & SRCLR_N;
  assign w_sr_next = {r_sr[WIDTH-2:0], SER};
  assign w_last    = w_shift & (r_state == ST_SHIFT) & (r_cnt == CW'(WIDTH - 1));
  assign w_auto    = AUTO_LATCH & w_last;
  assign w_latch   = w_auto | RCLK;

  // Frame FSM, shift register, storage register and status flags.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= ST_IDLE;
      r_sr         <= {WIDTH{1'b0}};
      r_store      <= {WIDTH{1'b0}};
      r_cnt        <= {CW{1'b0}};
      r_frame_done <= 1'b0;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (!SRCLR_N) begin
        r_sr    <= {WIDTH{1'b0}};
        r_cnt   <= {CW{1'b0}};
        r_state <= ST_IDLE;
      end else if (SRCLK_EN) begin
        r_sr <= w_sr_next;
        case (r_state)
          ST_IDLE: begin
            r_cnt   <= CW'(1);
            r_state <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (w_last) begin
              r_cnt   <= {CW{1'b0}};
              r_state <= ST_IDLE;
            end else begin
              r_cnt   <= r_cnt + CW'(1);
              r_state <= ST_SHIFT;
            end
          end
          default: begin
            r_cnt   <= {CW{1'b0}};
            r_state <= ST_IDLE;
          end
        endcase
      end else begin
        r_sr    <= r_sr;
        r_cnt   <= r_cnt;
        r_state <= r_state;
      end

      // Auto-latch takes the post-shift word; a manual latch takes the pre-shift (pre-clear) word.
      if (w_auto) begin
        r_store <= w_sr_next;
      end else if (RCLK) begin
        r_store <= r_sr;
      end else begin
        r_store <= r_store;
      end

      r_frame_done <= w_auto;

      if (w_latch) begin
        r_valid <= 1'b1;
      end else if (RD_ACK) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end

      if (w_latch && r_valid && !RD_ACK) begin
        r_overrun <= 1'b1;
      end else begin
        r_overrun <= r_overrun;
      end
    end
  end

  assign Q           = OE_N ? {WIDTH{1'b0}} : r_store;
  assign Q_OE        = ~OE_N;
  assign QH_S        = r_sr[WIDTH-1];
  assign BIT_CNT     = r_cnt;
  assign FRAME_DONE  = r_frame_done;
  assign STORE_VALID = r_valid;
  assign OVERRUN     = r_overrun;

endmodule

// File: tb/tb_ic_74595_sipo_rx.sv
// Bench for ic_74595_sipo_rx: an auto-latch and a manual-latch instance share the stimulus and are
// compared every cycle against a bit-queue reference model.
module tb_ic_74595_sipo_rx;

  localparam int W  = 8;
  localparam int CW = 4;

  logic CLK = 1'b0;
  logic RST_N, SER, SRCLK_EN, SRCLR_N, RCLK, RD_ACK, OE_N;

  logic [W-1:0]  q_o  [2];
  logic [CW-1:0] bc_o [2];
  logic          qoe_o[2], qh_o[2], fd_o[2], sv_o[2], ovr_o[2];

  ic_74595_sipo_rx #(.WIDTH(W), .AUTO_LATCH(1'b1)) u_auto (
    .CLK(CLK), .RST_N(RST_N), .SER(SER), .SRCLK_EN(SRCLK_EN), .SRCLR_N(SRCLR_N),
    .RCLK(RCLK), .RD_ACK(RD_ACK), .OE_N(OE_N), .Q(q_o[0]), .Q_OE(qoe_o[0]), .QH_S(qh_o[0]),
    .BIT_CNT(bc_o[0]), .FRAME_DONE(fd_o[0]), .STORE_VALID(sv_o[0]), .OVERRUN(ovr_o[0]));

  ic_74595_sipo_rx #(.WIDTH(W), .AUTO_LATCH(1'b0)) u_man (
    .CLK(CLK), .RST_N(RST_N), .SER(SER), .SRCLK_EN(SRCLK_EN), .SRCLR_N(SRCLR_N),
    .RCLK(RCLK), .RD_ACK(RD_ACK), .OE_N(OE_N), .Q(q_o[1]), .Q_OE(qoe_o[1]), .QH_S(qh_o[1]),
    .BIT_CNT(bc_o[1]), .FRAME_DONE(fd_o[1]), .STORE_VALID(sv_o[1]), .OVERRUN(ovr_o[1]));

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: the shift register is a queue of the last W shifted bits, oldest first.
  int hist[$];
  int m_cnt;
  int m_store[2];
  bit m_fd[2], m_valid[2], m_ovr[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sr_val();
    int v = 0;
    foreach (hist[i]) v = v * 2 + hist[i];
    return v;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (W) hist.push_back(0);
    m_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      m_store[k] = 0; m_fd[k] = 0; m_valid[k] = 0; m_ovr[k] = 0;
    end
  endtask

  task automatic model_edge();
    int  old_sr = sr_val();
    bit  done   = SRCLK_EN && SRCLR_N && (m_cnt + 1 == W);
    if (!SRCLR_N) begin
      hist.delete();
      repeat (W) hist.push_back(0);
      m_cnt = 0;
    end else if (SRCLK_EN) begin
      void'(hist.pop_front());
      hist.push_back(int'(SER));
      m_cnt = (m_cnt + 1) % W;
    end
    for (int k = 0; k < 2; k++) begin
      bit auto_l = (k == 0) && done;
      bit latch  = auto_l || RCLK;
      if (auto_l) m_store[k] = sr_val();
      else if (RCLK) m_store[k] = old_sr;
      if (latch && m_valid[k] && !RD_ACK) m_ovr[k] = 1'b1;
      if (latch) m_valid[k] = 1'b1;
      else if (RD_ACK) m_valid[k] = 1'b0;
      m_fd[k] = auto_l;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("q%0d", k),     32'(q_o[k]),   OE_N ? 32'd0 : 32'(m_store[k]));
      chk($sformatf("qoe%0d", k),   32'(qoe_o[k]), 32'(!OE_N));
      chk($sformatf("qh%0d", k),    32'(qh_o[k]),  32'(hist[0]));
      chk($sformatf("cnt%0d", k),   32'(bc_o[k]),  32'(m_cnt));
      chk($sformatf("fd%0d", k),    32'(fd_o[k]),  32'(m_fd[k]));
      chk($sformatf("valid%0d", k), 32'(sv_o[k]),  32'(m_valid[k]));
      chk($sformatf("ovr%0d", k),   32'(ovr_o[k]), 32'(m_ovr[k]));
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input bit ser, input bit en, input bit clr_n, input bit rclk, input bit ack);
    SER = ser; SRCLK_EN = en; SRCLR_N = clr_n; RCLK = rclk; RD_ACK = ack;
    step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = W - 1; i >= 0; i--) drive(b[i], 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    SER = 1'b0; SRCLK_EN = 1'b0; SRCLR_N = 1'b1; RCLK = 1'b0; RD_ACK = 1'b0;
    RST_N = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  logic [15:0] pat;

  initial begin
    OE_N = 1'b0;
    do_reset();

    // Reset mid-frame is seen without a clock edge.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_cnt", 32'(bc_o[0]), 32'd0);
    chk("rst_qh", 32'(qh_o[0]), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    send_byte(8'hA5);
    chk("a5_q", 32'(q_o[0]), 32'hA5);
    chk("a5_fd", 32'(fd_o[0]), 32'd1);
    chk("a5_valid", 32'(sv_o[0]), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("a5_fd_end", 32'(fd_o[0]), 32'd0);

    // Back-to-back frames with acknowledge after each.
    do_reset();
    pat = 16'h3CC3;
    for (int i = 0; i < 16; i++) begin
      drive(pat[15-i], 1'b1, 1'b1, 1'b0, i == 8);
      if (i == 7) chk("b2b_q1", 32'(q_o[0]), 32'h3C);
    end
    chk("b2b_q2", 32'(q_o[0]), 32'hC3);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("b2b_ovr", 32'(ovr_o[0]), 32'd0);

    // Overrun: two frames without acknowledge; sticky until reset.
    do_reset();
    send_byte(8'h11);
    send_byte(8'h22);
    chk("ovr_set", 32'(ovr_o[0]), 32'd1);
    chk("ovr_q", 32'(q_o[0]), 32'h22);
    repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("ovr_sticky", 32'(ovr_o[0]), 32'd1);

    // Manual latch takes the pre-shift word.
    do_reset();
    send_byte(8'h0F);
    chk("man_noauto", 32'(sv_o[1]), 32'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("man_q", 32'(q_o[1]), 32'h0F);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("man_qh", 32'(qh_o[1]), 32'd1);

    // Clear mid-frame beats the shift strobe and leaves storage alone.
    do_reset();
    send_byte(8'h5A);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("clr_cnt", 32'(bc_o[0]), 32'd0);
    chk("clr_q", 32'(q_o[0]), 32'h5A);
    send_byte(8'h81);
    chk("clr_q81", 32'(q_o[0]), 32'h81);

    // Output enable gating.
    do_reset();
    send_byte(8'hFF);
    OE_N = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("oe_q0", 32'(q_o[0]), 32'd0);
    chk("oe_qoe0", 32'(qoe_o[0]), 32'd0);
    OE_N = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("oe_qff", 32'(q_o[0]), 32'hFF);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      OE_N = ($urandom_range(0, 7) == 0);
      drive(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 31) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
